fpmu_result_tx: RTL and testbench

- Result-side transmitter of the FP16 multiply unit.
- Accepts a raw product from the multiplier datapath:
  - sign
  - 6-bit biased-exponent sum
  - 22-bit significand product
- Normalizes, rounds to nearest-even and packs it into an IEEE 754 half-precision word.
- Streams the word out as two bytes over an 8-bit valid/ack output port toward the pin bus.

---
 rtl/fpmu_result_tx.sv | 186 ++++++++++++++++++
 tb/tb_fpmu_result_tx.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/fpmu_result_tx.sv
// FP16 multiply result transmitter: normalizes a raw product, rounds, packs to half precision
// and streams it as two bytes. Build option: FPMU_TX_ROUND_EN (RNE rounding; truncation when undefined).
module fpmu_result_tx #(
  parameter int unsigned BIAS = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sign,
  input  logic [5:0]  in_exp,
  input  logic [21:0] in_mant,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ack,
  output logic        busy,
  output logic        ovf,
  output logic        unf
);

  localparam int unsigned EXP_W  = 6;
  localparam int unsigned MANT_W = 22;
  localparam int unsigned SIG_W  = 11;
  localparam int unsigned E_W    = 7;
  localparam int unsigned RES_W  = 16;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    NORM    = 3'd1,
    ROUND   = 3'd2,
    SEND_HI = 3'd3,
    SEND_LO = 3'd4
  } state_e;

  state_e                  state_q;
  logic                    sign_q;
  logic [EXP_W-1:0]        exp_q;
  logic [MANT_W-1:0]       mant_q;
  logic [SIG_W-1:0]        sig_q;
  logic signed [E_W-1:0]   e_q;
  logic                    zero_q;
  logic [RES_W-1:0]        result_q;
  logic [7:0]              tx_data_q;
  logic                    tx_valid_q;
  logic                    ovf_q;
  logic                    unf_q;
`ifdef FPMU_TX_ROUND_EN
  logic                    guard_q;
  logic                    sticky_q;
  logic                    guard_d;
  logic                    sticky_d;
`endif

  logic [SIG_W-1:0]        sig_d;
  logic signed [E_W-1:0]   e_d;
  logic                    zero_d;
  logic                    inc_d;
  logic [SIG_W:0]          sig_sum_d;
  logic signed [E_W-1:0]   e_rnd_d;
  logic [9:0]              frac_d;
  logic [RES_W-1:0]        result_d;
  logic                    ovf_d;
  logic                    unf_d;

  // Normalize: a product of two 1.x significands lies in [1,4); bit 21 selects the extra shift.
  always_comb begin
    sig_d  = mant_q[21] ? mant_q[21:11] : mant_q[20:10];
    e_d    = E_W'(exp_q) - E_W'(BIAS) + E_W'(mant_q[21]);
    zero_d = (mant_q == '0);
`ifdef FPMU_TX_ROUND_EN
    guard_d  = mant_q[21] ? mant_q[10] : mant_q[9];
    sticky_d = mant_q[21] ? (|mant_q[9:0]) : (|mant_q[8:0]);
`endif
  end

  // Round and pack; a carry out of the significand bumps the exponent.
  always_comb begin
`ifdef FPMU_TX_ROUND_EN
    inc_d = guard_q & (sticky_q | sig_q[0]);
`else
    inc_d = 1'b0;
`endif
    sig_sum_d = {1'b0, sig_q} + (SIG_W+1)'(inc_d);
    if (sig_sum_d[SIG_W]) begin
      frac_d  = sig_sum_d[10:1];
      e_rnd_d = e_q + E_W'(1);
    end else begin
      frac_d  = sig_sum_d[9:0];
      e_rnd_d = e_q;
    end

    result_d = {sign_q, 15'h0};
    ovf_d    = 1'b0;
    unf_d    = 1'b0;
    if (zero_q) begin
      result_d = {sign_q, 15'h0};
    end else if (e_rnd_d >= 7'sd31) begin
      result_d = {sign_q, 5'h1F, 10'h0};
      ovf_d    = 1'b1;
    end else if (e_rnd_d <= 7'sd0) begin
      result_d = {sign_q, 15'h0};
      unf_d    = 1'b1;
    end else begin
      result_d = {sign_q, e_rnd_d[4:0], frac_d};
    end
  end

  // Control FSM with registered byte-stream outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      sign_q     <= 1'b0;
      exp_q      <= '0;
      mant_q     <= '0;
      sig_q      <= '0;
      e_q        <= '0;
      zero_q     <= 1'b0;
      result_q   <= '0;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
`ifdef FPMU_TX_ROUND_EN
      guard_q    <= 1'b0;
      sticky_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            sign_q  <= in_sign;
            exp_q   <= in_exp;
            mant_q  <= in_mant;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            state_q <= NORM;
          end
        end
        NORM: begin
          sig_q    <= sig_d;
          e_q      <= e_d;
          zero_q   <= zero_d;
`ifdef FPMU_TX_ROUND_EN
          guard_q  <= guard_d;
          sticky_q <= sticky_d;
`endif
          state_q  <= ROUND;
        end
        ROUND: begin
          result_q   <= result_d;
          ovf_q      <= ovf_d;
          unf_q      <= unf_d;
          tx_data_q  <= result_d[15:8];
          tx_valid_q <= 1'b1;
          state_q    <= SEND_HI;
        end
        SEND_HI: begin
          if (tx_ack) begin
            tx_data_q <= result_q[7:0];
            state_q   <= SEND_LO;
          end
        end
        SEND_LO: begin
          if (tx_ack) begin
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            state_q    <= IDLE;
          end
        end
        default: begin
          tx_data_q  <= 8'h00;
          tx_valid_q <= 1'b0;
          state_q    <= IDLE;
        end
      endcase
    end
  end

  assign in_ready = (state_q == IDLE);
  assign busy     = (state_q != IDLE);
  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign ovf      = ovf_q;
  assign unf      = unf_q;

endmodule

// File: tb/tb_fpmu_result_tx.sv
// Directed bench for fpmu_result_tx: packed results, latency, backpressure and mid-transfer reset.
module tb_fpmu_result_tx;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [5:0]  in_exp;
  logic [21:0] in_mant;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ack;
  logic        busy;
  logic        ovf;
  logic        unf;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef FPMU_TX_ROUND_EN
  localparam logic [15:0] TIE_RES    = 16'h3C02;
  localparam logic [15:0] CARRY_RES  = 16'h4000;
  localparam logic [15:0] STICKY_RES = 16'h3C01;
`else
  localparam logic [15:0] TIE_RES    = 16'h3C01;
  localparam logic [15:0] CARRY_RES  = 16'h3FFF;
  localparam logic [15:0] STICKY_RES = 16'h3C00;
`endif

  fpmu_result_tx #(.BIAS(15)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_sign  (in_sign),
    .in_exp   (in_exp),
    .in_mant  (in_mant),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ack   (tx_ack),
    .busy     (busy),
    .ovf      (ovf),
    .unf      (unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One full transaction with tx_ack held high; checks every cycle of the 5-cycle window.
  task automatic run_vec(input string tag, input logic s, input logic [5:0] e,
                         input logic [21:0] m, input logic [15:0] res,
                         input logic eo, input logic eu);
    @(negedge clk);
    in_sign  = s;
    in_exp   = e;
    in_mant  = m;
    in_valid = 1'b1;
    check({tag, "_rdy"}, 16'(in_ready), 16'h1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check({tag, "_busy"}, 16'({busy, in_ready}), 16'h2);
    @(posedge clk); #1;
    check({tag, "_norm_v"}, 16'(tx_valid), 16'h0);
    @(posedge clk); #1;
    check({tag, "_hi"}, 16'({tx_valid, tx_data}), {7'h0, 1'b1, res[15:8]});
    @(posedge clk); #1;
    check({tag, "_lo"}, 16'({tx_valid, tx_data}), {7'h0, 1'b1, res[7:0]});
    @(posedge clk); #1;
    check({tag, "_idle"}, 16'({tx_valid, in_ready, busy}), 16'h2);
    check({tag, "_flags"}, 16'({ovf, unf}), 16'({eo, eu}));
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

  initial begin
    rst      = 1'b0;
    in_valid = 1'b0;
    in_sign  = 1'b0;
    in_exp   = '0;
    in_mant  = '0;
    tx_ack   = 1'b1;
    #2 rst = 1'b1;
    #1;
    check("rst_vals", 16'({tx_valid, in_ready, busy, ovf, unf}), 16'b01000);
    check("rst_data", 16'(tx_data), 16'h0000);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    run_vec("mul225",  1'b0, 6'd30, 22'h240000, 16'h4080, 1'b0, 1'b0);
    run_vec("tie",     1'b0, 6'd30, 22'h100600, TIE_RES,  1'b0, 1'b0);
    run_vec("carry",   1'b0, 6'd30, 22'h1FFE00, CARRY_RES, 1'b0, 1'b0);
    run_vec("sticky",  1'b0, 6'd30, 22'h100201, STICKY_RES, 1'b0, 1'b0);
    run_vec("tie_evn", 1'b0, 6'd30, 22'h100200, 16'h3C00, 1'b0, 1'b0);
    run_vec("ovf",     1'b1, 6'd60, 22'h100000, 16'hFC00, 1'b1, 1'b0);
    run_vec("unf",     1'b1, 6'd10, 22'h100000, 16'h8000, 1'b0, 1'b1);
    run_vec("zero",    1'b1, 6'd30, 22'h000000, 16'h8000, 1'b0, 1'b0);
    run_vec("emax",    1'b0, 6'd45, 22'h100000, 16'h7800, 1'b0, 1'b0);
    run_vec("e31",     1'b0, 6'd46, 22'h100000, 16'h7C00, 1'b1, 1'b0);
    run_vec("e31_b21", 1'b0, 6'd45, 22'h200000, 16'h7C00, 1'b1, 1'b0);
    run_vec("emin",    1'b0, 6'd16, 22'h100000, 16'h0400, 1'b0, 1'b0);
    run_vec("e0",      1'b0, 6'd15, 22'h100000, 16'h0000, 1'b0, 1'b1);

    // Backpressure: hold the high byte, inject an in_valid pulse that must be dropped.
    @(negedge clk);
    tx_ack   = 1'b0;
    in_sign  = 1'b0;
    in_exp   = 6'd30;
    in_mant  = 22'h240000;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    check("bp_first", 16'({tx_valid, tx_data}), 16'h0140);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 2) begin
        in_sign  = 1'b1;
        in_exp   = 6'd60;
        in_mant  = 22'h100000;
        in_valid = 1'b1;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("bp_hold", 16'({in_ready, tx_valid, tx_data}), 16'h0140);
    end
    @(negedge clk);
    tx_ack = 1'b1;
    @(posedge clk); #1;
    check("bp_lo", 16'({tx_valid, tx_data}), 16'h0180);
    @(posedge clk); #1;
    check("bp_idle", 16'({tx_valid, in_ready, ovf, unf}), 16'b0100);
    @(posedge clk); #1;
    check("bp_noq", 16'({busy, in_ready}), 16'h1);

    // Reset while parked in SEND_LO.
    @(negedge clk);
    in_sign  = 1'b0;
    in_exp   = 6'd30;
    in_mant  = 22'h240000;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk); #1;
    tx_ack = 1'b0;
    check("mr_lo", 16'({tx_valid, tx_data}), 16'h0180);
    #2 rst = 1'b1;
    #1;
    check("mr_rst", 16'({tx_valid, in_ready, busy}), 16'b010);
    check("mr_data", 16'(tx_data), 16'h0000);
    @(negedge clk);
    rst    = 1'b0;
    tx_ack = 1'b1;
    run_vec("post_rst", 1'b0, 6'd30, 22'h240000, 16'h4080, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
